// File: rtl/rop3_stream.sv
// Streaming ROP3 evaluator: two-stage valid/ready pipeline computing any of the 256 ternary
// raster ops per bit lane, with per-frame beat counting on the output side.
module rop3_stream #(
  parameter int unsigned N      = 8,
  parameter bit          LEGACY = 1'b0,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_p,
  input  logic [N-1:0]     in_s,
  input  logic [N-1:0]     in_d,
  input  logic [7:0]       in_mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_result,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_len,
  output logic             frame_done
);

  logic             s1_v_q, s2_v_q;
  logic [N-1:0]     s1_p_q, s1_s_q, s1_d_q;
  logic [7:0]       s1_mode_q;
  logic             s1_last_q;
  logic [N-1:0]     s2_result_q;
  logic             s2_last_q;
  logic [CNT_W-1:0] cnt_q, frame_len_q;
  logic             frame_done_q;

  logic             s2_free, s1_free, in_hs, out_hs;
  logic             mode_ok;
  logic [7:0]       eff_mode;
  logic [N-1:0]     result_d;

  always_comb begin
    s2_free = ~s2_v_q | out_ready;
    s1_free = ~s1_v_q | s2_free;
    in_hs   = in_valid & s1_free;
    out_hs  = s2_v_q & out_ready;
  end

  always_comb begin
    case (s1_mode_q)
      8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
      8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: mode_ok = 1'b1;
      default:                                         mode_ok = 1'b0;
    endcase
  end

  // Each result bit selects one bit of the mode byte, indexed by {p,s,d} with p as MSB.
  always_comb begin
    eff_mode = (LEGACY && !mode_ok) ? 8'h00 : s1_mode_q;
    result_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      result_d[i] = eff_mode[{s1_p_q[i], s1_s_q[i], s1_d_q[i]}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q       <= 1'b0;
      s1_p_q       <= '0;
      s1_s_q       <= '0;
      s1_d_q       <= '0;
      s1_mode_q    <= '0;
      s1_last_q    <= 1'b0;
      s2_v_q       <= 1'b0;
      s2_result_q  <= '0;
      s2_last_q    <= 1'b0;
      cnt_q        <= '0;
      frame_len_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      if (s1_free) begin
        s1_v_q <= in_valid;
      end
      if (in_hs) begin
        s1_p_q    <= in_p;
        s1_s_q    <= in_s;
        s1_d_q    <= in_d;
        s1_mode_q <= in_mode;
        s1_last_q <= in_last;
      end
      // Stage 2 reloads in the same cycle it hands off, so there is no bubble.
      if (s2_free) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          s2_result_q <= result_d;
          s2_last_q   <= s1_last_q;
        end
      end
      frame_done_q <= out_hs & s2_last_q;
      if (out_hs) begin
        if (s2_last_q) begin
          frame_len_q <= cnt_q + CNT_W'(1);
          cnt_q       <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready   = s1_free;
  assign out_valid  = s2_v_q;
  assign out_result = s2_result_q;
  assign out_last   = s2_last_q;
  assign frame_len  = frame_len_q;
  assign frame_done = frame_done_q;

endmodule
